// File: rtl/pc_ras_pkg.sv
// Shared types and helpers for the fetch-stage program counter with return-address stack.
// Holds the command encoding, the strobe priority encoder and the sign-extension helper.
package pc_ras_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    INC  = 3'd1,
    BR   = 3'd2,
    LD   = 3'd3,
    CALL = 3'd4,
    RET  = 3'd5
  } pc_cmd_e;

  // Stall is not a command of its own: a stalled cycle behaves exactly like HOLD.
  function automatic pc_cmd_e sel_cmd(input logic stall, input logic ret, input logic call,
                                      input logic ld, input logic br, input logic inc);
    pc_cmd_e c;
    if (stall)     c = HOLD;
    else if (ret)  c = RET;
    else if (call) c = CALL;
    else if (ld)   c = LD;
    else if (br)   c = BR;
    else if (inc)  c = INC;
    else           c = HOLD;
    return c;
  endfunction

  // Sign-extend the low w bits of v to MAX_W bits; bits above w in v must be zero.
  function automatic logic [MAX_W-1:0] sign_ext(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] t;
    mask = {MAX_W{1'b1}} << w;
    t    = v >> (w - 1);
    return t[0] ? (v | mask) : (v & ~mask);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push past capacity silently overwrites the oldest entry.
// A pop on an empty stack leaves the pointer and count untouched.
module ras_stack
  import pc_ras_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           top_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign top_o   = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (!full_o) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage has no reset; the count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[ptr_q + PTR_W'(1)] <= data_i;
  end

endmodule

// File: rtl/pc_ras.sv
// Fetch-stage program counter with relative branch, call/return and a circular RAS.
// Owns the PC register, the per-cycle command selection and the sticky overflow/underflow flags.
module pc_ras
  import pc_ras_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               STEP      = 1,
  parameter int               OFF_W     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       inc,
  input  logic                       ld,
  input  logic [WIDTH-1:0]           ld_addr,
  input  logic                       br,
  input  logic [OFF_W-1:0]           br_off,
  input  logic                       call,
  input  logic                       ret,
  output logic [WIDTH-1:0]           pc,
  output logic [$clog2(DEPTH+1)-1:0] ras_count,
  output logic                       ras_full,
  output logic                       ras_empty,
  output logic                       ras_ovf,
  output logic                       ras_unf
);

  pc_cmd_e          cmd;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] off_ext;
  logic [WIDTH-1:0] ret_addr;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push, pop;

  assign cmd     = sel_cmd(stall, ret, call, ld, br, inc);
  assign off_ext = WIDTH'(sign_ext(MAX_W'(br_off), OFF_W));
  assign push    = (cmd == CALL);
  assign pop     = (cmd == RET);

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pc_q + WIDTH'(STEP)),
    .top_o   (ret_addr),
    .count_o (ras_count),
    .full_o  (ras_full),
    .empty_o (ras_empty)
  );

  // All sums wrap modulo 2^WIDTH by construction of the operand widths.
  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    case (cmd)
      RET: begin
        if (ras_empty) unf_d = 1'b1;
        else           pc_d  = ret_addr;
      end
      CALL: begin
        pc_d = ld_addr;
        if (ras_full) ovf_d = 1'b1;
      end
      LD:      pc_d = ld_addr;
      BR:      pc_d = pc_q + off_ext;
      INC:     pc_d = pc_q + WIDTH'(STEP);
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign pc      = pc_q;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;

endmodule

// File: tb/tb_pc_ras.sv
// Bench for pc_ras: a LIFO-queue reference model checked every cycle, directed literal checks,
// then a randomized command stream. A second small instance covers WIDTH=8, STEP=2 wrap.
module tb_pc_ras;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT (defaults) ----------------
  logic        stall, inc, ld, br, call, ret;
  logic [15:0] ld_addr;
  logic [7:0]  br_off;
  logic [15:0] pc;
  logic [2:0]  ras_count;
  logic        ras_full, ras_empty, ras_ovf, ras_unf;

  pc_ras #(.WIDTH(16), .STEP(1), .OFF_W(8), .DEPTH(4), .RESET_VEC(16'h0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .inc(inc), .ld(ld), .ld_addr(ld_addr),
    .br(br), .br_off(br_off), .call(call), .ret(ret), .pc(pc), .ras_count(ras_count),
    .ras_full(ras_full), .ras_empty(ras_empty), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  // ---------------- small DUT (WIDTH=8, STEP=2) ----------------
  logic       t_stall, t_inc, t_ld, t_br, t_call, t_ret;
  logic [7:0] t_addr, t_off;
  logic [7:0] t_pc;
  logic [2:0] t_count;
  logic       t_full, t_empty, t_ovf, t_unf;

  pc_ras #(.WIDTH(8), .STEP(2), .OFF_W(8), .DEPTH(4), .RESET_VEC(8'h00)) dut8 (
    .clk(clk), .reset(reset), .stall(t_stall), .inc(t_inc), .ld(t_ld), .ld_addr(t_addr),
    .br(t_br), .br_off(t_off), .call(t_call), .ret(t_ret), .pc(t_pc), .ras_count(t_count),
    .ras_full(t_full), .ras_empty(t_empty), .ras_ovf(t_ovf), .ras_unf(t_unf)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] exp_q[$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc = 16'h0000;
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (stall) begin
      // frozen
    end else if (ret) begin
      if (exp_q.size() > 0) m_pc = exp_q.pop_back();
      else                  m_unf = 1'b1;
    end else if (call) begin
      exp_q.push_back(16'(int'(m_pc) + 1));
      if (exp_q.size() > 4) begin
        void'(exp_q.pop_front());
        m_ovf = 1'b1;
      end
      m_pc = ld_addr;
    end else if (ld) begin
      m_pc = ld_addr;
    end else if (br) begin
      m_pc = 16'(int'(m_pc) + int'($signed(br_off)));
    end else if (inc) begin
      m_pc = 16'(int'(m_pc) + 1);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", 32'(pc), 32'(m_pc));
      check("ras_count", 32'(ras_count), 32'(exp_q.size()));
      check("ras_full", 32'(ras_full), 32'(exp_q.size() == 4));
      check("ras_empty", 32'(ras_empty), 32'(exp_q.size() == 0));
      check("ras_ovf", 32'(ras_ovf), 32'(m_ovf));
      check("ras_unf", 32'(ras_unf), 32'(m_unf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cmd(input logic s, input logic r, input logic c, input logic l,
                     input logic b, input logic i, input logic [15:0] a, input logic [7:0] o);
    stall = s; ret = r; call = c; ld = l; br = b; inc = i; ld_addr = a; br_off = o;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    cmd(0, 0, 0, 0, 0, 0, 16'h0, 8'h0);
  endtask

  task automatic cmd8(input logic r, input logic c, input logic l, input logic i,
                      input logic [7:0] a);
    t_ret = r; t_call = c; t_ld = l; t_inc = i; t_addr = a;
    @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] rets [4];
    stall = 0; inc = 0; ld = 0; br = 0; call = 0; ret = 0; ld_addr = '0; br_off = '0;
    t_stall = 0; t_inc = 0; t_ld = 0; t_br = 0; t_call = 0; t_ret = 0; t_addr = '0; t_off = '0;

    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_empty", 32'(ras_empty), 32'h1);
    check("rst_flags", 32'({ras_ovf, ras_unf}), 32'h0);
    reset = 1'b1;

    // increment
    cmd(0, 0, 0, 0, 0, 1, 16'h0, 8'h0); check("inc1", 32'(pc), 32'h1);
    cmd(0, 0, 0, 0, 0, 1, 16'h0, 8'h0); check("inc2", 32'(pc), 32'h2);
    cmd(0, 0, 0, 0, 0, 1, 16'h0, 8'h0); check("inc3", 32'(pc), 32'h3);

    // branch backwards and wrap
    cmd(0, 0, 0, 1, 0, 0, 16'h0010, 8'h0);
    cmd(0, 0, 0, 0, 1, 0, 16'h0, 8'hF8); check("br_neg", 32'(pc), 32'h0008);
    cmd(0, 0, 0, 1, 0, 0, 16'hFFFF, 8'h0);
    cmd(0, 0, 0, 0, 0, 1, 16'h0, 8'h0); check("inc_wrap", 32'(pc), 32'h0000);

    // call/return nesting
    cmd(0, 0, 0, 1, 0, 0, 16'h0005, 8'h0);
    cmd(0, 0, 1, 0, 0, 0, 16'h0100, 8'h0);
    check("call1_pc", 32'(pc), 32'h0100); check("call1_cnt", 32'(ras_count), 32'h1);
    cmd(0, 0, 1, 0, 0, 0, 16'h0200, 8'h0); check("call2_cnt", 32'(ras_count), 32'h2);
    cmd(0, 1, 0, 0, 0, 0, 16'h0, 8'h0); check("ret1_pc", 32'(pc), 32'h0101);
    cmd(0, 1, 0, 0, 0, 0, 16'h0, 8'h0); check("ret2_pc", 32'(pc), 32'h0006);
    check("ret2_empty", 32'(ras_empty), 32'h1);

    // overflow: five calls from pc=0x0006
    for (int k = 0; k < 5; k++) cmd(0, 0, 1, 0, 0, 0, 16'(16'h1000 + 16 * k), 8'h0);
    check("ovf_full", 32'(ras_full), 32'h1);
    check("ovf_flag", 32'(ras_ovf), 32'h1);
    check("ovf_cnt", 32'(ras_count), 32'h4);
    rets[0] = 16'h1031; rets[1] = 16'h1021; rets[2] = 16'h1011; rets[3] = 16'h1001;
    for (int k = 0; k < 4; k++) begin
      cmd(0, 1, 0, 0, 0, 0, 16'h0, 8'h0);
      check($sformatf("lifo_%0d", k), 32'(pc), 32'(rets[k]));
    end
    cmd(0, 1, 0, 0, 0, 0, 16'h0, 8'h0);
    check("unf_hold", 32'(pc), 32'h1001);
    check("unf_flag", 32'(ras_unf), 32'h1);

    // priority and stall
    cmd(0, 0, 0, 1, 0, 0, 16'h0300, 8'h0);
    cmd(0, 0, 1, 0, 0, 0, 16'h0400, 8'h0);
    cmd(0, 1, 1, 0, 0, 1, 16'h0500, 8'h0);
    check("prio_pc", 32'(pc), 32'h0301); check("prio_cnt", 32'(ras_count), 32'h0);
    cmd(1, 0, 1, 0, 0, 0, 16'h0600, 8'h0);
    check("stall_pc", 32'(pc), 32'h0301); check("stall_cnt", 32'(ras_count), 32'h0);
    cmd(0, 0, 0, 1, 1, 0, 16'h0123, 8'h05); check("ld_over_br", 32'(pc), 32'h0123);

    // asynchronous reset between edges after two calls
    cmd(0, 0, 1, 0, 0, 0, 16'h0700, 8'h0);
    cmd(0, 0, 1, 0, 0, 0, 16'h0800, 8'h0);
    check("pre_rst_cnt", 32'(ras_count), 32'h2);
    idle();
    #2 reset = 1'b0;
    #1;
    check("arst_pc", 32'(pc), 32'h0);
    check("arst_cnt", 32'(ras_count), 32'h0);
    check("arst_flags", 32'({ras_ovf, ras_unf}), 32'h0);
    @(negedge clk);
    #1 reset = 1'b1;
    cmd(0, 0, 0, 0, 0, 1, 16'h0, 8'h0); check("post_rst_inc", 32'(pc), 32'h1);

    // WIDTH=8, STEP=2 instance
    cmd8(0, 0, 1, 0, 8'hFE); check("w8_ld", 32'(t_pc), 32'hFE);
    cmd8(0, 0, 0, 1, 8'h00); check("w8_wrap", 32'(t_pc), 32'h00);
    cmd8(0, 0, 0, 1, 8'h00); check("w8_inc", 32'(t_pc), 32'h02);
    cmd8(0, 1, 0, 0, 8'h40); check("w8_call", 32'(t_pc), 32'h40);
    cmd8(1, 0, 0, 0, 8'h00); check("w8_ret", 32'(t_pc), 32'h04);
    cmd8(0, 0, 0, 0, 8'h00);

    // randomized stream
    for (int n = 0; n < 3000; n++) begin
      cmd($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
          16'($urandom), 8'($urandom));
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b0;
        #3 reset = 1'b1;
      end
    end
    idle();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_ras.md
Name: pc_ras

Overview:
- Parametrised program counter, successor to the fixed 16-bit PC.
- Adds configurable width, increment step and reset vector.
- Adds signed relative branch, call/return, and a circular return-address stack (RAS) with full/empty status and sticky overflow/underflow flags.
- Sits in the fetch stage; its `pc` output drives instruction-memory address.

Parameters:
- WIDTH, 16, PC and address width in bits (>=8).
- STEP, 1, increment applied by `inc` and pushed by `call` as the return offset.
- OFF_W, 8, branch offset width, two's complement (2..WIDTH).
- DEPTH, 4, RAS entries; power of 2, >=2.
- RESET_VEC, 0, PC value loaded by reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset, asynchronous assertion, active-low.
- stall  in  1  freezes PC and RAS when high.
- inc  in  1  advance PC by STEP.
- ld  in  1  absolute jump to `ld_addr`.
- ld_addr  in  WIDTH  jump/call target.
- br  in  1  relative branch.
- br_off  in  OFF_W  signed branch offset, relative to current `pc`.
- call  in  1  push `pc+STEP`, then jump to `ld_addr`.
- ret  in  1  pop top of RAS into PC.
- pc  out  WIDTH  current program counter, registered.
- ras_count  out  $clog2(DEPTH+1)  valid entries.
- ras_full  out  1  ras_count==DEPTH.
- ras_empty  out  1  ras_count==0.
- ras_ovf  out  1  sticky: a call occurred while full.
- ras_unf  out  1  sticky: a ret occurred while empty.

Behaviour:
- Reset (reset low, asynchronous assertion):
  - pc=RESET_VEC, ras_count=0, top pointer=0.
  - ras_ovf=0, ras_unf=0.
  - RAS storage contents don't-care.
  - Reset mid-operation discards all state; the first edge after release applies normal priority.
- All updates occur on the rising clk edge. Latency is 1 cycle: pc reflects a command on the edge after it is sampled.
- Priority per cycle, only the highest applies: stall > ret > call > ld > br > inc > hold.
  - stall: pc, RAS and flags unchanged, including sticky flags.
  - ret, count>0: pc<=RAS[top]; top decrements modulo DEPTH; count-1.
  - ret, count==0: pc holds; ras_unf<=1; count stays 0.
  - call, count<DEPTH: RAS[top+1]<=pc+STEP; top increments; count+1; pc<=ld_addr.
  - call, count==DEPTH: same write/pointer advance, which overwrites the oldest entry; count stays DEPTH; ras_ovf<=1; pc<=ld_addr.
  - ld: pc<=ld_addr.
  - br: pc<=pc+sign_extend(br_off).
  - inc: pc<=pc+STEP.
  - none asserted: pc holds.
- Arithmetic: all sums are modulo 2^WIDTH, so wrap is silent. Example: WIDTH=16, pc=0xFFFF, inc gives 0x0000.
- call and ret in the same cycle: ret wins, call is ignored entirely (no push).
- ras_full, ras_empty and ras_count are registered-state derived with no combinational path from inputs.
- ras_ovf and ras_unf clear only on reset.

Decomposition:
- Package pc_ras_pkg holds:
  - the pc_cmd_e enum (HOLD, INC, BR, LD, CALL, RET);
  - the priority encoder function mapping input strobes to pc_cmd_e;
  - the sign-extension helper.
- Sub-module ras_stack (parametrised WIDTH, DEPTH): circular storage, top pointer, count, push/pop, full/empty.
- pc_ras owns the PC register, command selection and the sticky flags.

Test Plan (all at defaults unless noted):
- Reset and increment: hold reset low, release, inc high 3 cycles -> pc 0,1,2,3; ras_empty=1; flags 0.
- Branch and wrap:
  - pc=0x0010, br_off=0xF8 (-8) -> pc=0x0008.
  - ld_addr=0xFFFF, then inc -> pc=0x0000.
  - STEP=2, WIDTH=8 run: pc=0xFE, inc -> 0x00.
- Call/return nesting:
  - pc=0x0005, call 0x0100 -> pc=0x0100, count=1.
  - call 0x0200 -> count=2.
  - ret -> pc=0x0101; ret -> pc=0x0006; ras_empty=1.
- Overflow and underflow:
  - 5 calls with DEPTH=4 -> ras_full=1, ras_ovf=1, count=4.
  - 4 rets return the newest four addresses in LIFO order.
  - 5th ret -> pc holds, ras_unf=1.
- Priority and stall:
  - call+ret+inc in one cycle -> only the pop occurs.
  - stall high with call -> pc and count unchanged.
  - ld+br -> pc=ld_addr.
- Asynchronous reset mid-call: assert reset between edges after 2 calls -> pc=RESET_VEC immediately, count=0, flags 0.
